pulse_sequencer: RTL

- Trigger-sequencing controller for the hardware timing path.
- On a rising edge of a start request, emits a programmed burst of fixed-width output pulses at a fixed period.
- Provides busy and done status, plus abort.
- Downstream exposure/display trigger logic consumes pulse_out. Upstream control logic programs cfg_* and issues start, typically as a level.

---
 rtl/pulse_seq_pkg.sv | 14 +
 rtl/pulse_sequencer_pulse_gen.sv | 24 ++
 rtl/pulse_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared types and default widths for the pulse sequencer.
package pulse_seq_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        FIN
    } seq_state_t;

endpackage

// File: rtl/pulse_sequencer_pulse_gen.sv
// Single-cycle pulse generator: one registered strobe per rising edge of i_in_pulse.
module pulse_sequencer_pulse_gen (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in_pulse,
    output logic o_out_pulse
);

    logic r_in_q;
    logic r_out;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_q <= 1'b0;
            r_out  <= 1'b0;
        end else begin
            r_in_q <= i_in_pulse;
            r_out  <= i_in_pulse & ~r_in_q;
        end
    end

    assign o_out_pulse = r_out;

endmodule

// File: rtl/pulse_sequencer.sv
// Burst trigger sequencer: on a start edge emits cfg_count pulses of width w at period p.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [IDX_W-1:0] i_cfg_count,
    input  logic [CNT_W-1:0] i_cfg_width,
    input  logic [CNT_W-1:0] i_cfg_period,
    output logic             o_pulse_out,
    output logic [IDX_W-1:0] o_pulse_idx,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] C_IDX_1 = IDX_W'(1);

    logic             w_start_edge;
    logic [CNT_W-1:0] w_width;
    logic [CNT_W:0]   w_width_p1;
    logic [CNT_W-1:0] w_period;

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_count;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_period;
    logic [IDX_W-1:0] r_idx;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;

    pulse_sequencer_pulse_gen u_start_edge (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_pulse  (i_start),
        .o_out_pulse (w_start_edge)
    );

    // An all-ones width gives up one cycle so the mandatory low cycle still fits in p.
    always_comb begin
        w_width = i_cfg_width;
        if (i_cfg_width == '0)
            w_width = C_ONE;
        else if (&i_cfg_width)
            w_width = i_cfg_width - C_ONE;
        w_width_p1 = {1'b0, w_width} + {{CNT_W{1'b0}}, 1'b1};
        w_period   = i_cfg_period;
        if (w_width_p1 > {1'b0, i_cfg_period})
            w_period = w_width_p1[CNT_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_count  <= '0;
            r_width  <= '0;
            r_period <= '0;
            r_idx    <= '0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_state <= IDLE;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_start_edge) begin
                            r_count  <= i_cfg_count;
                            r_width  <= w_width;
                            r_period <= w_period;
                            r_idx    <= '0;
                            if (i_cfg_count == '0) begin
                                r_state <= FIN;
                            end else begin
                                r_state <= HIGH;
                                r_pulse <= 1'b1;
                                r_busy  <= 1'b1;
                                r_cnt   <= C_ONE;
                            end
                        end
                    end
                    HIGH: begin
                        r_cnt <= r_cnt + C_ONE;
                        if (r_cnt == r_width) begin
                            r_pulse <= 1'b0;
                            // The last pulse's trailing low cycle is the FIN cycle.
                            r_state <= (r_idx == r_count - C_IDX_1) ? FIN : LOW;
                        end
                    end
                    LOW: begin
                        if (r_cnt == r_period) begin
                            r_state <= HIGH;
                            r_pulse <= 1'b1;
                            r_idx   <= r_idx + C_IDX_1;
                            r_cnt   <= C_ONE;
                        end else begin
                            r_cnt <= r_cnt + C_ONE;
                        end
                    end
                    FIN: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_pulse_out = r_pulse;
    assign o_pulse_idx = r_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
